// File: rtl/axi_lite_pkg.sv
// Shared types and helpers for the AXI4-Lite memory responder.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_HAVE_A,
    WR_HAVE_D,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_RESP
  } rd_state_t;

  // True when a byte address falls inside the decoded window [0, mem_bytes).
  function automatic logic addr_in_range(input logic [63:0] addr, input logic [63:0] mem_bytes);
    return addr < mem_bytes;
  endfunction

endpackage

// File: rtl/axi_lite_byte_ram.sv
// Byte-lane RAM: one byte-enabled write port, one registered read port.
// A read and write to the same word on the same edge returns the old word.
module axi_lite_byte_ram #(
  parameter int NB    = 8,
  parameter int WORDS = 512,
  parameter int IDX_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [NB-1:0]     wstrb,
  input  logic [NB*8-1:0]   wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [NB*8-1:0]   rdata
);

  logic [NB*8-1:0] mem [WORDS];

  // Byte-lane write; storage itself is never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Registered read; holds its value until the next read request.
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_lite_mem_responder.sv
// AXI4-Lite subordinate backed by a byte-enabled RAM.
// Handshake rule on every channel: a transfer happens on the rising edge
// where VALID and READY are both high; a source holds VALID and its payload
// stable until that edge, and READY never depends on VALID.
module axi_lite_mem_responder
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int ID_W      = 4,
  parameter int MEM_BYTES = 4096
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ID_W-1:0]     AWID,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [ID_W-1:0]     BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ID_W-1:0]     ARID,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [ID_W-1:0]     RID,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY,
  output logic [1:0]          wr_state_dbg,
  output logic                rd_state_dbg
);

  localparam int NB     = DATA_W / 8;
  localparam int WORDS  = MEM_BYTES / NB;
  localparam int IDX_W  = $clog2(WORDS);
  localparam int OFS_W  = $clog2(NB);
  localparam int MEM_AW = $clog2(MEM_BYTES);

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  // Held low through reset and for the edge of release so no READY is seen during reset.
  logic ready_en;

  logic              aw_hs, w_hs, ar_hs, wr_commit;
  logic [ADDR_W-1:0] aw_addr_q, wr_addr;
  logic [ID_W-1:0]   aw_id_q, wr_id;
  logic [DATA_W-1:0] w_data_q, wr_data;
  logic [NB-1:0]     w_strb_q, wr_strb;
  logic              wr_ok, rd_ok, rd_err;
  logic [DATA_W-1:0] ram_rdata;

  // READY enable comes up one cycle after reset is released.
  always_ff @(posedge ACLK) begin
    if (ARESET) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // Write FSM state register.
  always_ff @(posedge ACLK) begin
    if (ARESET) wr_state <= WR_IDLE;
    else        wr_state <= wr_next;
  end

  // Write FSM: channel readiness, commit detection and next state.
  always_comb begin
    wr_next   = wr_state;
    AWREADY   = 1'b0;
    WREADY    = 1'b0;
    BVALID    = 1'b0;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    wr_commit = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        AWREADY = ready_en;
        WREADY  = ready_en;
        aw_hs   = AWVALID && ready_en;
        w_hs    = WVALID && ready_en;
        if (aw_hs && w_hs) begin
          wr_commit = 1'b1;
          wr_next   = WR_RESP;
        end else if (aw_hs) begin
          wr_next = WR_HAVE_A;
        end else if (w_hs) begin
          wr_next = WR_HAVE_D;
        end
      end
      WR_HAVE_A: begin
        WREADY = 1'b1;
        w_hs   = WVALID;
        if (w_hs) begin
          wr_commit = 1'b1;
          wr_next   = WR_RESP;
        end
      end
      WR_HAVE_D: begin
        AWREADY = 1'b1;
        aw_hs   = AWVALID;
        if (aw_hs) begin
          wr_commit = 1'b1;
          wr_next   = WR_RESP;
        end
      end
      WR_RESP: begin
        BVALID = 1'b1;
        if (BREADY) wr_next = WR_IDLE;
      end
      default: wr_next = WR_IDLE;
    endcase
  end

  // Capture each write channel's payload when it is accepted on its own.
  always_ff @(posedge ACLK) begin
    if (aw_hs) begin
      aw_addr_q <= AWADDR;
      aw_id_q   <= AWID;
    end
    if (w_hs) begin
      w_data_q <= WDATA;
      w_strb_q <= WSTRB;
    end
  end

  // Commit uses the live channel if it handshakes now, else the captured copy.
  always_comb begin
    wr_addr = aw_hs ? AWADDR : aw_addr_q;
    wr_id   = aw_hs ? AWID   : aw_id_q;
    wr_data = w_hs  ? WDATA  : w_data_q;
    wr_strb = w_hs  ? WSTRB  : w_strb_q;
    wr_ok   = addr_in_range(64'(wr_addr), 64'(MEM_BYTES));
  end

  // Write response registers, loaded on commit and held through backpressure.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      BID   <= '0;
      BRESP <= OKAY;
    end else if (wr_commit) begin
      BID   <= wr_id;
      BRESP <= wr_ok ? OKAY : SLVERR;
    end
  end

  // Read FSM state register.
  always_ff @(posedge ACLK) begin
    if (ARESET) rd_state <= RD_IDLE;
    else        rd_state <= rd_next;
  end

  // Read FSM: accept one address, then hold the response until taken.
  always_comb begin
    rd_next = rd_state;
    ARREADY = 1'b0;
    RVALID  = 1'b0;
    ar_hs   = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        ARREADY = ready_en;
        ar_hs   = ARVALID && ready_en;
        if (ar_hs) rd_next = RD_RESP;
      end
      RD_RESP: begin
        RVALID = 1'b1;
        if (RREADY) rd_next = RD_IDLE;
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  always_comb rd_ok = addr_in_range(64'(ARADDR), 64'(MEM_BYTES));

  // Read response registers, loaded on the AR handshake.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      RID    <= '0;
      RRESP  <= OKAY;
      rd_err <= 1'b0;
    end else if (ar_hs) begin
      RID    <= ARID;
      RRESP  <= rd_ok ? OKAY : SLVERR;
      rd_err <= !rd_ok;
    end
  end

  // Out-of-range reads return zero instead of whatever word aliased in the RAM.
  always_comb RDATA = rd_err ? '0 : ram_rdata;

  assign RLAST        = 1'b1;
  assign wr_state_dbg = wr_state;
  assign rd_state_dbg = rd_state;

  axi_lite_byte_ram #(
    .NB    (NB),
    .WORDS (WORDS),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (ACLK),
    .rst   (ARESET),
    .we    (wr_commit && wr_ok),
    .waddr (wr_addr[MEM_AW-1:OFS_W]),
    .wstrb (wr_strb),
    .wdata (wr_data),
    .re    (ar_hs),
    .raddr (ARADDR[MEM_AW-1:OFS_W]),
    .rdata (ram_rdata)
  );

endmodule
